// File: rtl/snes_bus_strobe_if.sv
// Raw SNES control/bus pins plus the conditioned strobes and status bits derived from them.
// master drives the pins (board side); slave is the conditioner.
interface snes_bus_strobe_if;
   logic        SNES_READ;
   logic        SNES_WRITE;
   logic        SNES_CPU_CLK;
   logic        SNES_RESET;
   logic [23:0] SNES_ADDR;
   logic [7:0]  SNES_DATA;
   logic        SNES_rd_strobe;
   logic        SNES_wr_strobe;
   logic        SNES_cycle_start;
   logic        SNES_reset_strobe;
   logic        snes_ajr;
   logic        pad_latch;

   modport master (
      output SNES_READ, SNES_WRITE, SNES_CPU_CLK, SNES_RESET, SNES_ADDR, SNES_DATA,
      input  SNES_rd_strobe, SNES_wr_strobe, SNES_cycle_start, SNES_reset_strobe,
      input  snes_ajr, pad_latch
   );

   modport slave (
      input  SNES_READ, SNES_WRITE, SNES_CPU_CLK, SNES_RESET, SNES_ADDR, SNES_DATA,
      output SNES_rd_strobe, SNES_wr_strobe, SNES_cycle_start, SNES_reset_strobe,
      output snes_ajr, pad_latch
   );
endinterface

// File: rtl/snes_bus_strobe.sv
// SNES /RD /WR PHI2 /RESET conditioner: sync, optional glitch filter (SNES_STROBE_FILTER_EN), 1-clk strobes, $4200/$4016 tracking.
// Latency 2+STROBE_FILTER clk (3 unfiltered), PHI2 and reset 3 clk; no backpressure, strobes are fire-and-forget.
module snes_bus_strobe #(
   parameter int STROBE_FILTER = 3,
   parameter int RESET_HOLD    = 16
) (
   input logic              clk,
   input logic              reset,
   snes_bus_strobe_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} trk_t;

   localparam logic [7:0] HOLD = 8'(RESET_HOLD);

   generate
      if (STROBE_FILTER < 1 || STROBE_FILTER > 8) begin : g_bad_filter
         $error("STROBE_FILTER must be 1..8");
      end
      if (RESET_HOLD < 2 || RESET_HOLD > 255) begin : g_bad_hold
         $error("RESET_HOLD must be 2..255");
      end
   endgenerate

   logic [1:0] rd_sync;
   logic [1:0] wr_sync;
   logic [1:0] phi_sync;
   logic [1:0] rst_sync;
   logic       phi_d;
   logic       rd_s;
   logic       wr_s;
   logic       phi_s;
   logic       rst_s;

   assign rd_s  = rd_sync[1];
   assign wr_s  = wr_sync[1];
   assign phi_s = phi_sync[1];
   assign rst_s = rst_sync[1];

   // Presetting to 1 makes every line look inactive right after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_sync  <= '1;
         wr_sync  <= '1;
         phi_sync <= '1;
         rst_sync <= '1;
         phi_d    <= 1'b1;
      end else begin
         rd_sync  <= {rd_sync[0], bus.SNES_READ};
         wr_sync  <= {wr_sync[0], bus.SNES_WRITE};
         phi_sync <= {phi_sync[0], bus.SNES_CPU_CLK};
         rst_sync <= {rst_sync[0], bus.SNES_RESET};
         phi_d    <= phi_s;
      end
   end

   trk_t rd_st;
   trk_t rd_nxt;
   trk_t wr_st;
   trk_t wr_nxt;

`ifdef SNES_STROBE_FILTER_EN
   logic [STROBE_FILTER-1:0] rd_sh;
   logic [STROBE_FILTER-1:0] wr_sh;
   logic [STROBE_FILTER-1:0] rd_win;
   logic [STROBE_FILTER-1:0] wr_win;

   // The window includes this clock's sample so the state flips on the clock it qualifies.
   always_comb begin
      rd_win    = rd_sh << 1;
      rd_win[0] = rd_s;
      wr_win    = wr_sh << 1;
      wr_win[0] = wr_s;
      rd_nxt    = rd_st;
      wr_nxt    = wr_st;
      if (rd_win == '0) begin
         rd_nxt = ACTIVE;
      end else if (rd_win == '1) begin
         rd_nxt = IDLE;
      end
      if (wr_win == '0) begin
         wr_nxt = ACTIVE;
      end else if (wr_win == '1) begin
         wr_nxt = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_sh <= '1;
         wr_sh <= '1;
      end else begin
         rd_sh <= rd_win;
         wr_sh <= wr_win;
      end
   end
`else
   always_comb begin
      rd_nxt = rd_s ? IDLE : ACTIVE;
      wr_nxt = wr_s ? IDLE : ACTIVE;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_st <= IDLE;
         wr_st <= IDLE;
      end else begin
         rd_st <= rd_nxt;
         wr_st <= wr_nxt;
      end
   end

   // Suppression looks at the other tracker's post-update state so simultaneous edges still count as contention.
   logic rd_fire;
   logic wr_fire;

   always_comb begin
      rd_fire = (rd_st == IDLE) && (rd_nxt == ACTIVE) && (wr_nxt != ACTIVE);
      wr_fire = (wr_st == ACTIVE) && (wr_nxt == IDLE) && (rd_nxt != ACTIVE);
   end

   logic [7:0] rcnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.SNES_rd_strobe    <= 1'b0;
         bus.SNES_wr_strobe    <= 1'b0;
         bus.SNES_cycle_start  <= 1'b0;
         bus.SNES_reset_strobe <= 1'b0;
         rcnt                  <= 8'd0;
      end else begin
         bus.SNES_rd_strobe    <= rd_fire;
         bus.SNES_wr_strobe    <= wr_fire;
         bus.SNES_cycle_start  <= phi_s & ~phi_d;
         bus.SNES_reset_strobe <= rst_s && (rcnt == HOLD);
         if (rst_s) begin
            rcnt <= 8'd0;
         end else if (rcnt != HOLD) begin
            rcnt <= rcnt + 8'd1;
         end
      end
   end

   logic bank_ok;
   logic hit_4200;
   logic hit_4016;

   // Bank bit 22 clear selects $00-$3F and $80-$BF, the banks that mirror the CPU I/O page.
   always_comb begin
      bank_ok  = ~bus.SNES_ADDR[22];
      hit_4200 = bank_ok && (bus.SNES_ADDR[15:0] == 16'h4200);
      hit_4016 = bank_ok && (bus.SNES_ADDR[15:0] == 16'h4016);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.snes_ajr  <= 1'b0;
         bus.pad_latch <= 1'b0;
      end else if (bus.SNES_reset_strobe) begin
         bus.snes_ajr  <= 1'b0;
         bus.pad_latch <= 1'b0;
      end else if (bus.SNES_wr_strobe) begin
         if (hit_4200) begin
            bus.snes_ajr <= bus.SNES_DATA[0];
         end
         if (hit_4016 && bus.SNES_DATA[0]) begin
            bus.pad_latch <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_snes_bus_strobe.sv
// Bench for snes_bus_strobe: directed scenarios plus random pin activity against a pin-history reference model.
module tb_snes_bus_strobe;

`ifdef SNES_STROBE_FILTER_EN
   localparam int F = 3;
`else
   localparam int F = 1;
`endif
   localparam int HOLD = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;

   snes_bus_strobe_if bus ();

   snes_bus_strobe #(.STROBE_FILTER(3), .RESET_HOLD(HOLD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: pin values seen at each edge; a line's synced value at edge t is the pin at edge t-2.
   bit h_rd[32], h_wr[32], h_phi[32], h_rst[32];
   bit e_rd = 0, e_wr = 0, e_cs = 0, e_rs = 0, m_ajr = 0, m_pad = 0;
   bit m_rda = 0, m_wra = 0;
   int m_rcnt = 0;
   int t = 0;

   always @(posedge clk) begin : model
      bit a0r, a1r, a0w, a1w, nr, nw, rs;
      logic [7:0] bank;
      t++;
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            h_rd[i] = 1; h_wr[i] = 1; h_phi[i] = 1; h_rst[i] = 1;
         end
         m_rda = 0; m_wra = 0; m_rcnt = 0;
         e_rd = 0; e_wr = 0; e_cs = 0; e_rs = 0; m_ajr = 0; m_pad = 0;
      end else begin
         h_rd[t & 31]  = bus.SNES_READ;
         h_wr[t & 31]  = bus.SNES_WRITE;
         h_phi[t & 31] = bus.SNES_CPU_CLK;
         h_rst[t & 31] = bus.SNES_RESET;
         if (e_rs) begin
            m_ajr = 0; m_pad = 0;
         end else if (e_wr) begin
            bank = bus.SNES_ADDR[23:16];
            if (bank <= 8'h3F || (bank >= 8'h80 && bank <= 8'hBF)) begin
               if (bus.SNES_ADDR[15:0] == 16'h4200) m_ajr = bus.SNES_DATA[0];
               if (bus.SNES_ADDR[15:0] == 16'h4016 && bus.SNES_DATA[0]) m_pad = 1;
            end
         end
         a0r = 1; a1r = 1; a0w = 1; a1w = 1;
         for (int k = 0; k < F; k++) begin
            a0r &= !h_rd[(t - 2 - k) & 31]; a1r &= h_rd[(t - 2 - k) & 31];
            a0w &= !h_wr[(t - 2 - k) & 31]; a1w &= h_wr[(t - 2 - k) & 31];
         end
         nr = a0r ? 1'b1 : (a1r ? 1'b0 : m_rda);
         nw = a0w ? 1'b1 : (a1w ? 1'b0 : m_wra);
         e_rd = !m_rda && nr && !nw;
         e_wr = m_wra && !nw && !nr;
         m_rda = nr; m_wra = nw;
         e_cs = h_phi[(t - 2) & 31] && !h_phi[(t - 3) & 31];
         rs = h_rst[(t - 2) & 31];
         e_rs = rs && (m_rcnt == HOLD);
         if (rs) m_rcnt = 0;
         else if (m_rcnt < HOLD) m_rcnt++;
      end
   end

   function automatic logic [5:0] obs_vec();
      return {bus.SNES_rd_strobe, bus.SNES_wr_strobe, bus.SNES_cycle_start,
              bus.SNES_reset_strobe, bus.snes_ajr, bus.pad_latch};
   endfunction

   function automatic logic [5:0] exp_vec();
      return {e_rd, e_wr, e_cs, e_rs, m_ajr, m_pad};
   endfunction

   task automatic test_reset();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++;
         if (obs_vec() !== 6'b0) begin
            bad++; $display("FAIL reset_state c=%0d got=%b want=000000", c, obs_vec());
         end
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL reset_model c=%0d got=%b want=%b", c, obs_vec(), exp_vec());
         end
      end
      reset = 0;
   endtask

   task automatic test_read();
      int n_rd = 0, n_wr = 0, first = -1;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL read c=%0d got=%b want=%b", c, obs_vec(), exp_vec());
         end
         if (bus.SNES_rd_strobe) begin n_rd++; if (first < 0) first = c; end
         if (bus.SNES_wr_strobe) n_wr++;
         bus.SNES_READ = !(c < 10);
      end
      total++;
      if (n_rd !== 1) begin bad++; $display("FAIL read_count got=%0d want=1", n_rd); end
      total++;
      if (first !== F + 2) begin bad++; $display("FAIL read_latency got=%0d want=%0d", first, F + 2); end
      total++;
      if (n_wr !== 0) begin bad++; $display("FAIL read_no_wr got=%0d want=0", n_wr); end
   endtask

   task automatic test_write_decode();
      int n_wr = 0, cw[2] = '{-1, -1}, ca = -1, cp = -1;
      bit pa = 0, pp = 0;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL write c=%0d got=%b want=%b", c, obs_vec(), exp_vec());
         end
         if (bus.SNES_wr_strobe) begin if (n_wr < 2) cw[n_wr] = c; n_wr++; end
         if (bus.snes_ajr && !pa && ca < 0) ca = c;
         if (bus.pad_latch && !pp && cp < 0) cp = c;
         pa = bus.snes_ajr; pp = bus.pad_latch;
         bus.SNES_WRITE = !((c < 6) || (c >= 20 && c < 26));
         bus.SNES_ADDR  = (c < 20) ? 24'h004200 : 24'h804016;
         bus.SNES_DATA  = 8'h01;
      end
      total++;
      if (n_wr !== 2) begin bad++; $display("FAIL write_count got=%0d want=2", n_wr); end
      total++;
      if (cw[0] !== 8 + F) begin bad++; $display("FAIL write_latency got=%0d want=%0d", cw[0], 8 + F); end
      total++;
      if (ca !== cw[0] + 1) begin bad++; $display("FAIL ajr_timing got=%0d want=%0d", ca, cw[0] + 1); end
      total++;
      if (cp !== cw[1] + 1) begin bad++; $display("FAIL pad_timing got=%0d want=%0d", cp, cw[1] + 1); end
      total++;
      if ({bus.snes_ajr, bus.pad_latch} !== 2'b11) begin
         bad++; $display("FAIL write_final got=%b want=11", {bus.snes_ajr, bus.pad_latch});
      end
   endtask

   task automatic test_glitch();
      int n_wr = 0, n_rd = 0, want;
      want = (F > 1) ? 0 : 1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL glitch c=%0d got=%b want=%b", c, obs_vec(), exp_vec());
         end
         if (bus.SNES_wr_strobe) n_wr++;
         if (bus.SNES_rd_strobe) n_rd++;
         bus.SNES_WRITE = !(c < 2);
      end
      total++;
      if (n_wr !== want) begin bad++; $display("FAIL glitch_wr got=%0d want=%0d", n_wr, want); end
      total++;
      if (n_rd !== 0) begin bad++; $display("FAIL glitch_rd got=%0d want=0", n_rd); end
   endtask

   task automatic test_reset_qual();
      int lens[4] = '{15, 40, 16, 300};
      int wants[4] = '{0, 1, 1, 1};
      for (int p = 0; p < 4; p++) begin
         int n = 0, at = -1;
         for (int c = 0; c < lens[p] + 10; c++) begin
            @(negedge clk);
            total++;
            if (obs_vec() !== exp_vec()) begin
               bad++; $display("FAIL rstq p=%0d c=%0d got=%b want=%b", p, c, obs_vec(), exp_vec());
            end
            if (bus.SNES_reset_strobe) begin n++; at = c; end
            bus.SNES_RESET = !(c < lens[p]);
         end
         total++;
         if (n !== wants[p]) begin bad++; $display("FAIL rstq_count len=%0d got=%0d want=%0d", lens[p], n, wants[p]); end
         if (wants[p] == 1) begin
            total++;
            if (at !== lens[p] + 3) begin bad++; $display("FAIL rstq_latency len=%0d got=%0d want=%0d", lens[p], at, lens[p] + 3); end
         end
         if (p == 0) begin
            total++;
            if ({bus.snes_ajr, bus.pad_latch} !== 2'b11) begin
               bad++; $display("FAIL rstq_short_keeps got=%b want=11", {bus.snes_ajr, bus.pad_latch});
            end
         end
         if (p == 1) begin
            total++;
            if ({bus.snes_ajr, bus.pad_latch} !== 2'b00) begin
               bad++; $display("FAIL rstq_clear got=%b want=00", {bus.snes_ajr, bus.pad_latch});
            end
         end
      end
   endtask

   task automatic test_contention();
      int n_rd = 0, n_wr = 0, n_cs = 0, last = -1;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL contention c=%0d got=%b want=%b", c, obs_vec(), exp_vec());
         end
         if (bus.SNES_rd_strobe) n_rd++;
         if (bus.SNES_wr_strobe) n_wr++;
         if (bus.SNES_cycle_start) begin
            n_cs++;
            if (last >= 0) begin
               total++;
               if (c - last !== 6) begin bad++; $display("FAIL cycle_gap c=%0d got=%0d want=6", c, c - last); end
            end
            last = c;
         end
         bus.SNES_READ    = !(c < 20);
         bus.SNES_WRITE   = !(c < 10);
         bus.SNES_CPU_CLK = ((c / 3) % 2) == 1;
      end
      bus.SNES_CPU_CLK = 0;
      total++;
      if (n_rd + n_wr !== 0) begin bad++; $display("FAIL contention_strobes got=%0d want=0", n_rd + n_wr); end
      total++;
      if (n_cs < 6) begin bad++; $display("FAIL cycle_count got=%0d want>=6", n_cs); end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      bit prev = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL b2b c=%0d got=%b want=%b", c, obs_vec(), exp_vec());
         end
         if (bus.SNES_rd_strobe) n++;
         total++;
         if (prev && bus.SNES_rd_strobe) begin bad++; $display("FAIL b2b_width c=%0d got=1 want=0", c); end
         prev = bus.SNES_rd_strobe;
         bus.SNES_READ = !(c < 48 && (c % 8) < 4);
      end
      total++;
      if (n !== 6) begin bad++; $display("FAIL b2b_count got=%0d want=6", n); end
   endtask

   task automatic test_reset_mid();
      int n = 0, first = -1;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL midrst c=%0d got=%b want=%b", c, obs_vec(), exp_vec());
         end
         if (c == 2) begin
            total++;
            if (obs_vec() !== 6'b0) begin bad++; $display("FAIL midrst_state got=%b want=000000", obs_vec()); end
         end
         if (bus.SNES_rd_strobe) begin n++; if (first < 0) first = c; end
         bus.SNES_READ = !(c < 20);
         reset = (c == 1);
      end
      total++;
      if (n !== 1) begin bad++; $display("FAIL midrst_count got=%0d want=1", n); end
      total++;
      if (first !== F + 4) begin bad++; $display("FAIL midrst_latency got=%0d want=%0d", first, F + 4); end
   endtask

   task automatic test_random();
      int hr = 1, hw = 1, hp = 1, hs = 50;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL random c=%0d got=%b want=%b", c, obs_vec(), exp_vec());
         end
         if (--hr == 0) begin bus.SNES_READ = ~bus.SNES_READ; hr = $urandom_range(1, 8); end
         if (--hp == 0) begin bus.SNES_CPU_CLK = ~bus.SNES_CPU_CLK; hp = $urandom_range(1, 4); end
         if (--hw == 0) begin
            bus.SNES_WRITE = ~bus.SNES_WRITE;
            hw = $urandom_range(1, 8);
            if (!bus.SNES_WRITE) begin
               case ($urandom_range(0, 5))
                  0: bus.SNES_ADDR = 24'h004200;
                  1: bus.SNES_ADDR = 24'h804016;
                  2: bus.SNES_ADDR = 24'h404200;
                  3: bus.SNES_ADDR = 24'hC04016;
                  4: bus.SNES_ADDR = {2'b00, 6'($urandom), 16'h4016};
                  default: bus.SNES_ADDR = 24'($urandom);
               endcase
               bus.SNES_DATA = 8'($urandom);
            end
         end
         if (--hs == 0) begin
            bus.SNES_RESET = ~bus.SNES_RESET;
            hs = bus.SNES_RESET ? $urandom_range(20, 200) : $urandom_range(5, 30);
         end
         reset = ($urandom_range(0, 999) == 0);
      end
      reset = 0;
   endtask

   initial begin
      bus.SNES_READ = 1; bus.SNES_WRITE = 1; bus.SNES_CPU_CLK = 0; bus.SNES_RESET = 1;
      bus.SNES_ADDR = 24'h0; bus.SNES_DATA = 8'h0;
      test_reset();
      test_read();
      test_write_decode();
      test_glitch();
      test_reset_qual();
      test_contention();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/snes_bus_strobe.md
# snes_bus_strobe

Front-end conditioner for the SNES bus control lines. It synchronises the raw /RD, /WR, CPU clock and /RESET pins into the FPGA clock domain and filters glitches off the strobe lines. It then produces the single-cycle `SNES_rd_strobe`, `SNES_wr_strobe`, `SNES_cycle_start` and `SNES_reset_strobe` pulses that the cheat/hook logic consumes. It also tracks the CPU's joypad configuration and drives the `snes_ajr` and `pad_latch` status inputs of that logic.

## Interface
Parameters:
- `STROBE_FILTER`, 3: consecutive identical synchronised samples required to change /RD or /WR state (1..8).
- `RESET_HOLD`, 16: consecutive synchronised-low samples of /RESET required to qualify a reset (2..255).

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `SNES_READ`  in  1  raw /RD, active low.
- `SNES_WRITE`  in  1  raw /WR, active low.
- `SNES_CPU_CLK`  in  1  raw PHI2.
- `SNES_RESET`  in  1  raw /RESET, active low.
- `SNES_ADDR`  in  24  A-bus address, sampled only at write decode.
- `SNES_DATA`  in  8  data bus, sampled only at write decode.
- `SNES_rd_strobe`  out  1  one-clk pulse at start of a read.
- `SNES_wr_strobe`  out  1  one-clk pulse at end of a write.
- `SNES_cycle_start`  out  1  one-clk pulse per PHI2 rising edge.
- `SNES_reset_strobe`  out  1  one-clk pulse on release of a qualified reset.
- `snes_ajr`  out  1  last written $4200 bit 0 (auto-joypad read enable).
- `pad_latch`  out  1  sticky: game has latched $4016 manually.

## Operation
- Synchronisers: two-flop chain per raw input. Chains are preset to 1 (inactive) on `reset`.
- Filter trackers: /RD and /WR each have a state bit `act` (0 = IDLE, 1 = ACTIVE) and a sample shift register of `STROBE_FILTER` bits.
  - IDLE→ACTIVE when all samples are 0.
  - ACTIVE→IDLE when all samples are 1.
  - Mixed samples hold the state.
- `SNES_rd_strobe`: pulses on the rd IDLE→ACTIVE transition. It is suppressed if wr `act` = 1 in the same clock.
- `SNES_wr_strobe`: pulses on the wr ACTIVE→IDLE transition, so data is stable. It is suppressed if rd `act` = 1 in the same clock.
- Bus contention (both trackers ACTIVE): no strobes are emitted. Each tracker still follows its own samples.
- `SNES_cycle_start`: pulses on the synchronised PHI2 0→1 edge. There is no filtering.
- Reset qualifier:
  - 8-bit counter `rcnt`. It increments, saturating at `RESET_HOLD`, while synced /RESET = 0. It is cleared to 0 when /RESET = 1.
  - `SNES_reset_strobe` pulses on the clock where synced /RESET returns to 1 with `rcnt` == `RESET_HOLD`.
  - Shorter low pulses produce nothing.
- Register decode, evaluated on `SNES_wr_strobe` using `SNES_ADDR`/`SNES_DATA` as sampled that clock. Bank match means bank in $00-$3F or $80-$BF.
  - $4200: `snes_ajr` <= `SNES_DATA[0]`.
  - $4016 with `SNES_DATA[0]` = 1: `pad_latch` <= 1.
- `pad_latch` is cleared by `SNES_reset_strobe` or `reset`. `snes_ajr` is cleared by the same two events.
- If `SNES_reset_strobe` and a decoded write coincide, the clear wins.
- Every output resets to 0. The trackers reset to IDLE with samples all 1, `rcnt` = 0.

## Timing
- /RD falling edge to `SNES_rd_strobe`: 2 + `STROBE_FILTER` clocks (5 at default).
- /WR rising edge to `SNES_wr_strobe`: 2 + `STROBE_FILTER` clocks.
- PHI2 rising edge to `SNES_cycle_start`: 3 clocks.
- /RESET rising edge to `SNES_reset_strobe`: 3 clocks.
- `snes_ajr` and `pad_latch` update 1 clock after the `SNES_wr_strobe` pulse.
- Strobe widths are exactly 1 clock; the same strobe can never fire in two consecutive clocks.
- `reset` asserted mid-transaction returns everything to the reset state next clock. A bus line still low at release needs the full filter time before the next strobe.
- `rcnt` saturates and never wraps, however long /RESET is held.

## Configuration
- `SNES_STROBE_FILTER_EN` defined: /RD and /WR use the `STROBE_FILTER` filter described above.
- `SNES_STROBE_FILTER_EN` undefined: the filter is removed.
  - Each tracker follows the last synchronised sample directly.
  - Latency becomes 3 clocks.
  - The `STROBE_FILTER` parameter is ignored.
- All other behaviour is identical in both builds.

## Test plan
- /RD low for 10 clocks, then high → one `SNES_rd_strobe` 5 clocks after the falling edge; no `SNES_wr_strobe`.
- Write $01 to $004200, then $01 to $804016 → `snes_ajr` = 1, then `pad_latch` = 1, each 1 clock after its `SNES_wr_strobe`.
- /WR glitch low for 2 clocks (filter build) → no strobes. The same glitch in the unfiltered build → one `SNES_wr_strobe`.
- /RESET low for 15 clocks → no `SNES_reset_strobe`.
- /RESET low for 40 clocks → one `SNES_reset_strobe` 3 clocks after release; `snes_ajr` and `pad_latch` clear.
- /RD and /WR both low for 10 clocks, then /WR released → no strobes at any point. PHI2 at clk/6 alongside → `SNES_cycle_start` every 6 clocks.
